// File: rtl/draw_text_16x16_pkg.sv
// Shared constants and types for the 16x16 text overlay stage.
package draw_text_16x16_pkg;

  // Glyph cell and text grid geometry.
  localparam int CHAR_W    = 8;
  localparam int CHAR_H    = 16;
  localparam int TEXT_COLS = 16;
  localparam int TEXT_ROWS = 16;
  localparam int BOX_W     = CHAR_W * TEXT_COLS;
  localparam int BOX_H     = CHAR_H * TEXT_ROWS;

  // VGA timing widths.
  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 11;
  localparam int RGB_W    = 12;

  // Timing bundle carried alongside the pixel through the pipeline.
  typedef struct packed {
    logic [HCOUNT_W-1:0] hcount;
    logic [VCOUNT_W-1:0] vcount;
    logic                hsync;
    logic                vsync;
    logic                hblnk;
    logic                vblnk;
  } vga_timing_t;

  // Highlight blink phase: ON shows the highlight colour on the selected row.
  typedef enum logic {
    BLINK_OFF = 1'b0,
    BLINK_ON  = 1'b1
  } blink_phase_t;

endpackage

// File: rtl/draw_text_16x16_signal_delay.sv
// Fixed-length register delay line with asynchronous active-low reset.
module draw_text_16x16_signal_delay #(
  parameter int WIDTH   = 1,
  parameter int CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [CLK_DEL];

  // Shift din through CLK_DEL register stages.
  // NOTE: every stage is reset (it is a short flop chain, not a RAM) so the
  // delayed outputs read 0 as soon as reset asserts; sequential state uses
  // non-blocking assignments so all stages shift on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CLK_DEL; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < CLK_DEL; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[CLK_DEL-1];

endmodule

// File: rtl/draw_text_16x16.sv
// Overlays a 16x16 grid of 8x16 glyphs on the VGA pixel stream, with a
// frame-synchronous blinking highlight on one selected text row.
module draw_text_16x16
  import draw_text_16x16_pkg::*;
#(
  parameter logic [10:0] XPOS         = 11'd64,
  parameter logic [10:0] YPOS         = 11'd64,
  parameter logic [11:0] FG_COLOR     = 12'hFFF,
  parameter logic [11:0] HL_COLOR     = 12'hF80,
  parameter logic [5:0]  BLINK_FRAMES = 6'd30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic        sel_en,
  input  logic [3:0]  sel_row,
  output logic [7:0]  char_xy,
  output logic [3:0]  char_line,
  input  logic [7:0]  char_pixels,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  // Position relative to the box; unsigned wrap turns the range test into
  // a single compare per axis.
  logic [10:0] rel_x, rel_y;
  logic        in_box;

  assign rel_x  = hcount_in - XPOS;
  assign rel_y  = vcount_in - YPOS;
  assign in_box = !hblnk_in && !vblnk_in &&
                  (rel_x < 11'(BOX_W)) && (rel_y < 11'(BOX_H));

  // S1 registers (also address the char ROM), S2 alignment with the font ROM.
  logic [3:0]  col_q, row_q, line_q, row_d;
  logic [2:0]  xoff_q, xoff_d;
  logic        in_box_q, in_box_d;
  logic [11:0] rgb_d, rgb_out_q;

  // Pipeline registers for stages S1 and S2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q    <= '0;
      row_q    <= '0;
      line_q   <= '0;
      xoff_q   <= '0;
      in_box_q <= 1'b0;
      xoff_d   <= '0;
      row_d    <= '0;
      in_box_d <= 1'b0;
    end else begin
      col_q    <= rel_x[6:3];
      xoff_q   <= rel_x[2:0];
      row_q    <= rel_y[7:4];
      line_q   <= rel_y[3:0];
      in_box_q <= in_box;
      xoff_d   <= xoff_q;
      row_d    <= row_q;
      in_box_d <= in_box_q;
    end
  end

  assign char_xy   = {row_q, col_q};
  assign char_line = line_q;

  // Timing rides three stages; rgb rides two and is muxed into S3.
  vga_timing_t timing_in, timing_out;

  assign timing_in = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                       vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in};

  draw_text_16x16_signal_delay #(.WIDTH($bits(vga_timing_t)), .CLK_DEL(3)) u_timing_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (timing_in),
    .dout  (timing_out)
  );

  draw_text_16x16_signal_delay #(.WIDTH(RGB_W), .CLK_DEL(2)) u_rgb_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (rgb_in),
    .dout  (rgb_d)
  );

  // Blink FSM: frame counter and phase advance on each vsync rising edge.
  logic         vsync_q, vsync_next;
  logic [5:0]   cnt_q, cnt_next;
  blink_phase_t blink_q, blink_next;
  logic         sel_en_q, sel_en_next;
  logic [3:0]   sel_row_q, sel_row_next;
  logic         frame_tick;

  assign frame_tick = vsync_in & ~vsync_q;

  // Blink state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q   <= 1'b0;
      cnt_q     <= '0;
      blink_q   <= BLINK_OFF;
      sel_en_q  <= 1'b0;
      sel_row_q <= '0;
    end else begin
      vsync_q   <= vsync_next;
      cnt_q     <= cnt_next;
      blink_q   <= blink_next;
      sel_en_q  <= sel_en_next;
      sel_row_q <= sel_row_next;
    end
  end

  // Blink next state: selection is latched only at frame boundaries.
  // NOTE: every output is given a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    vsync_next   = vsync_in;
    cnt_next     = cnt_q;
    blink_next   = blink_q;
    sel_en_next  = sel_en_q;
    sel_row_next = sel_row_q;
    if (frame_tick) begin
      sel_en_next  = sel_en;
      sel_row_next = sel_row;
      if (cnt_q == BLINK_FRAMES - 6'd1) begin
        cnt_next   = '0;
        blink_next = (blink_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
      end else begin
        cnt_next = cnt_q + 6'd1;
      end
    end
  end

  // Blink output: glyph colour for the pixel entering S3 (pre-tick state).
  logic [11:0] glyph_color;

  always_comb begin
    glyph_color = FG_COLOR;
    if (sel_en_q && (row_d == sel_row_q) && (blink_q == BLINK_ON))
      glyph_color = HL_COLOR;
  end

  // bit7 of the font row is the leftmost pixel of the cell.
  logic pix;
  assign pix = char_pixels[3'd7 - xoff_d];

  // S3: recolour set glyph pixels inside the box, otherwise pass rgb through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rgb_out_q <= '0;
    else        rgb_out_q <= (in_box_d && pix) ? glyph_color : rgb_d;
  end

  assign rgb_out    = rgb_out_q;
  assign hcount_out = timing_out.hcount;
  assign vcount_out = timing_out.vcount;
  assign hsync_out  = timing_out.hsync;
  assign vsync_out  = timing_out.vsync;
  assign hblnk_out  = timing_out.hblnk;
  assign vblnk_out  = timing_out.vblnk;

endmodule
